// File: rtl/armleocpu_mem_pkg.sv
// armleocpu_mem_pkg: shared state type, burstcount decode and LFSR taps for the memory responder
package armleocpu_mem_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } state_t;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  function automatic logic [4:0] burst_beats(input logic [3:0] bc);
    return (bc == 4'd0) ? 5'd16 : {1'b0, bc};
  endfunction
endpackage

// File: rtl/mem_1w1r.sv
// mem_1w1r: one-write one-read synchronous storage with per-byte-lane write enables.
// Ports: clk; waddr/wen/wbe/wdata write port; raddr read address, rdata registered read data.
module mem_1w1r #(
  parameter int ELEMENTS_W = 10,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic [ELEMENTS_W-1:0] waddr,
  input  logic                  wen,
  input  logic [WIDTH/8-1:0]    wbe,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ELEMENTS_W-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  for (genvar i = 0; i < WIDTH/8; i++) begin : g_lane
    logic [7:0] storage [2**ELEMENTS_W];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (wen && wbe[i]) storage[waddr] <= wdata[8*i +: 8];
      q <= storage[raddr];
    end
    assign rdata[8*i +: 8] = q;
  end
endmodule

// File: rtl/armleocpu_mem_responder.sv
// armleocpu_mem_responder: burst memory-master responder backed by word-addressed storage.
// Ports: clk, rst_n (async active-low); m_address/m_burstcount/m_read/m_write/m_writedata/m_byteenable
// from the master; m_waitrequest/m_readdata/m_readdatavalid back to it.
// Optional: define ARMLEOCPU_MEM_RESPONDER_STALL_EN for LFSR-driven random stalls and read bubbles.
module armleocpu_mem_responder
  import armleocpu_mem_pkg::*;
#(
  parameter int DEPTH_W = 10,
  parameter int READ_LATENCY = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [33:0] m_address,
  input  logic [3:0]  m_burstcount,
  output logic        m_waitrequest,
  input  logic        m_read,
  output logic [31:0] m_readdata,
  output logic        m_readdatavalid,
  input  logic        m_write,
  input  logic [31:0] m_writedata,
  input  logic [3:0]  m_byteenable
);
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);
  state_t state;
  logic [DEPTH_W-1:0] base, cmd_idx, waddr, raddr;
  logic [3:0] beat, last, lat, cmd_last, beat_nxt;
  logic [31:0] rd_data;
  logic idle, stall, wr_acc, rd_acc;
  logic unused_addr;
`ifdef ARMLEOCPU_MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  assign stall = lfsr[0];
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, LFSR_TAPS};
  assign stall = 1'b0;
`endif
  assign unused_addr = ^{m_address[33:DEPTH_W+2], m_address[1:0]};
  assign idle = state == IDLE;
  assign cmd_idx = m_address[DEPTH_W+1:2];
  assign cmd_last = 4'(burst_beats(m_burstcount) - 5'd1);
  assign m_waitrequest = !rst_n || state == RD_WAIT || state == RD_BURST || stall;
  assign m_readdatavalid = rst_n && state == RD_BURST && !stall;
  assign m_readdata = m_readdatavalid ? rd_data : '0;
  assign wr_acc = m_write && !m_waitrequest;
  assign rd_acc = idle && m_read && !m_write && !m_waitrequest;
  // The read port always fetches the word to be presented next cycle, so data is ready on entry to RD_BURST.
  assign beat_nxt = m_readdatavalid ? beat + 4'd1 : beat;
  assign raddr = (idle ? cmd_idx : base) + DEPTH_W'(beat_nxt);
  assign waddr = idle ? cmd_idx : base + DEPTH_W'(beat);
  mem_1w1r #(.ELEMENTS_W(DEPTH_W), .WIDTH(32)) u_mem (
    .clk  (clk),
    .waddr(waddr),
    .wen  (wr_acc),
    .wbe  (m_byteenable),
    .wdata(m_writedata),
    .raddr(raddr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      beat <= '0;
      last <= '0;
      lat <= '0;
    end else begin
      case (state)
        IDLE:
          if (wr_acc) begin
            if (cmd_last != 4'd0) begin
              state <= WR_BURST;
              base <= cmd_idx;
              beat <= 4'd1;
              last <= cmd_last;
            end
          end else if (rd_acc) begin
            state <= (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
            base <= cmd_idx;
            beat <= '0;
            last <= cmd_last;
            lat <= LAT_INIT;
          end
        RD_WAIT: begin
          lat <= lat - 4'd1;
          if (lat == 4'd1) state <= RD_BURST;
        end
        RD_BURST:
          if (m_readdatavalid) begin
            beat <= (beat == last) ? 4'd0 : beat + 4'd1;
            if (beat == last) state <= IDLE;
          end
        WR_BURST:
          if (wr_acc) begin
            beat <= (beat == last) ? 4'd0 : beat + 4'd1;
            if (beat == last) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef DEBUG
  always_ff @(posedge clk)
    if (rst_n && idle && m_read && m_write && !m_waitrequest)
      $display("armleocpu_mem_responder: protocol error, read and write together at %h; read dropped", m_address);
`endif
endmodule

// File: tb/tb_armleocpu_mem_responder.sv
// tb_armleocpu_mem_responder: randomized scoreboard bench for the memory responder
module tb_armleocpu_mem_responder;
  localparam int RL = 2;
  localparam int WORDS = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [33:0] m_address = '0;
  logic [3:0] m_burstcount = '0;
  logic m_waitrequest;
  logic m_read = 1'b0;
  logic [31:0] m_readdata;
  logic m_readdatavalid;
  logic m_write = 1'b0;
  logic [31:0] m_writedata = '0;
  logic [3:0] m_byteenable = '0;
  logic [31:0] model [WORDS];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  armleocpu_mem_responder #(.DEPTH_W(10), .READ_LATENCY(RL), .LFSR_SEED(8'hA5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_address(m_address),
    .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest),
    .m_read(m_read),
    .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_byteenable(m_byteenable)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (m_readdatavalid) begin
      if (exp_q.size() == 0) check("unexpected_readdatavalid", 32'd1, 32'd0);
      else check("readdata", m_readdata, exp_q.pop_front());
    end
  task automatic wait_accept();
    int t = 0;
    @(negedge clk);
    while (m_waitrequest && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_within_bound", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1;
  endtask
  function automatic int nbeats(input logic [3:0] bc);
    return (bc == 4'd0) ? 16 : int'(bc);
  endfunction
  task automatic model_wr(input int w, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] v = model[w % WORDS];
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    model[w % WORDS] = v;
  endtask
  task automatic wr(input logic [33:0] a, input logic [3:0] bc, input logic [31:0] d0, input logic [3:0] be0, input bit rnd);
    int n = nbeats(bc);
    int w = int'(a[11:2]);
    logic [31:0] d;
    logic [3:0] be;
    for (int i = 0; i < n; i++) begin
      if (rnd && i > 0)
        while ($urandom_range(0, 2) == 0) begin
          m_write = 1'b0;
          m_read = 1'($urandom);
          m_address = {2'b0, $urandom};
          @(posedge clk);
          #1;
        end
      d = rnd ? $urandom : d0 + 32'(i);
      be = rnd ? 4'($urandom_range(0, 15)) : be0;
      m_write = 1'b1;
      m_read = 1'b0;
      m_address = (i == 0) ? a : {2'b0, $urandom};
      m_burstcount = (i == 0) ? bc : 4'($urandom);
      m_writedata = d;
      m_byteenable = be;
      wait_accept();
      model_wr(w + i, d, be);
    end
    m_write = 1'b0;
    m_read = 1'b0;
  endtask
  task automatic rd_issue(input logic [33:0] a, input logic [3:0] bc);
    int w = int'(a[11:2]);
    for (int i = 0; i < nbeats(bc); i++) exp_q.push_back(model[(w + i) % WORDS]);
    m_read = 1'b1;
    m_write = 1'b0;
    m_address = a;
    m_burstcount = bc;
    wait_accept();
    m_read = 1'b0;
    m_address = {2'b0, $urandom};
  endtask
  task automatic rd(input logic [33:0] a, input logic [3:0] bc);
    int k = 0;
    int first = 0;
    int hi = 0;
    bit low = 1'b0;
    rd_issue(a, bc);
    while (k < 100 && !low) begin
      @(negedge clk);
      k++;
      if (m_readdatavalid && first == 0) first = k;
      if (m_waitrequest) hi++;
      else low = 1'b1;
    end
    check("first_beat_latency", 32'(first), 32'(RL));
    check("waitrequest_cycles", 32'(hi), 32'(RL + nbeats(bc) - 1));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cnt;
    #1;
    check("reset_waitrequest", 32'(m_waitrequest), 32'd1);
    check("reset_readdatavalid", 32'(m_readdatavalid), 32'd0);
    check("reset_readdata", m_readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_waitrequest", 32'(m_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < WORDS / 16; i++) wr(34'(i * 64), 4'd0, 32'($urandom), 4'hF, 1'b0);
    wr(34'h100, 4'd1, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(34'h100, 4'd1);
    wr(34'h40, 4'd0, 32'd0, 4'hF, 1'b0);
    rd(34'h40, 4'd0);
    wr(34'h200, 4'd1, 32'h11223344, 4'hF, 1'b0);
    wr(34'h200, 4'd1, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(34'h200, 4'd1);
    m_read = 1'b1;
    m_write = 1'b1;
    m_address = 34'h8;
    m_burstcount = 4'd1;
    m_writedata = 32'h5;
    m_byteenable = 4'hF;
    wait_accept();
    model_wr(2, 32'h5, 4'hF);
    m_read = 1'b0;
    m_write = 1'b0;
    cnt = 0;
    repeat (RL + 4) begin
      @(negedge clk);
      if (m_readdatavalid) cnt++;
    end
    check("dropped_read_no_valid", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    rd(34'h8, 4'd1);
    wr(34'h1000, 4'd1, 32'hCAFEF00D, 4'hF, 1'b0);
    rd(34'h0, 4'd1);
    rd_issue(34'h40, 4'd0);
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 4; t++) begin
      @(negedge clk);
      if (m_readdatavalid) cnt++;
    end
    check("reached_beat3", 32'(cnt), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_burst_valid", 32'(m_readdatavalid), 32'd0);
    check("rst_mid_burst_waitrequest", 32'(m_waitrequest), 32'd1);
    check("rst_mid_burst_readdata", m_readdata, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_waitrequest", 32'(m_waitrequest), 32'd0);
    check("post_reset_no_valid", 32'(m_readdatavalid), 32'd0);
    @(posedge clk);
    #1;
    rd(34'h44, 4'd3);
    for (int i = 0; i < 40; i++) begin
      logic [33:0] a = {$urandom_range(0, 3), $urandom};
      logic [3:0] bc = 4'($urandom);
      if ($urandom_range(0, 1) == 1) wr(a, bc, 32'd0, 4'hF, 1'b1);
      else rd(a, bc);
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
